// File: rtl/cpu_pkg.sv
// Shared widths, state encoding and constants for the CPU memory-side stage.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } biu_state_t;

  // Read data returned when a read is aborted by timeout.
  localparam logic [DATA_W_DEF-1:0] BUS_ERR_DATA = '1;

endpackage

// File: rtl/biu_timeout_ctr.sv
// Counts REQ cycles without acknowledge; flags the cycle that completes the budget.
module biu_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  // High in the TIMEOUT-th consecutive unacknowledged cycle.
  assign expired_c = inc & (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_interface_unit.sv
// Turns control-FSM rd/wr strobes into req/ack memory transactions and stalls the CPU
// via cpu_en until each transaction completes or aborts.
module bus_interface_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  input  logic              datacontrol_en,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] ir_addr,
  input  logic [DATA_W-1:0] acc_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              cpu_en,
  output logic              bus_err
);

  biu_state_t        state;
  logic              rd_q, wr_q;
  logic              pend, pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;

  logic              rd_rise_c, wr_rise_c, start_c, illegal_c, legal_c;
  logic [ADDR_W-1:0] addr_sel_c;
  logic              ctr_clear_c, ctr_inc_c, expired_c;

  assign rd_rise_c  = rd & ~rd_q;
  assign wr_rise_c  = wr & ~wr_q;
  assign start_c    = rd_rise_c | wr_rise_c;
  // Simultaneous edges, or a write without the accumulator on the bus, are rejected.
  assign illegal_c  = (rd_rise_c & wr_rise_c) | (wr_rise_c & ~datacontrol_en);
  assign legal_c    = start_c & ~illegal_c;
  assign addr_sel_c = fetch ? pc_addr : ir_addr;

  assign ctr_clear_c = (state != REQ);
  assign ctr_inc_c   = (state == REQ) & ~mem_ack;

  biu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ctr_clear_c),
    .inc       (ctr_inc_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      pend        <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      cpu_en      <= 1'b1;
      bus_err     <= 1'b0;
    end else begin
      rd_q        <= rd;
      wr_q        <= wr;
      rdata_valid <= 1'b0;
      bus_err     <= illegal_c;
      case (state)
        IDLE: begin
          // A parked request launches first; a fresh edge in the same cycle re-parks.
          if (pend | legal_c) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            cpu_en    <= 1'b0;
            mem_we    <= pend ? pend_we    : wr_rise_c;
            mem_addr  <= pend ? pend_addr  : addr_sel_c;
            mem_wdata <= pend ? pend_wdata : acc_data;
            pend      <= pend & legal_c;
            if (pend & legal_c) begin
              pend_we    <= wr_rise_c;
              pend_addr  <= addr_sel_c;
              pend_wdata <= acc_data;
            end
          end
        end
        REQ: begin
          if (start_c) bus_err <= 1'b1;
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we) begin
              rdata       <= mem_rdata;
              rdata_valid <= 1'b1;
            end
          end else if (expired_c) begin
            state   <= ERR;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (!mem_we) begin
              rdata       <= {DATA_W{1'b1}};
              rdata_valid <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          state  <= IDLE;
          cpu_en <= 1'b1;
          if (legal_c) begin
            pend       <= 1'b1;
            pend_we    <= wr_rise_c;
            pend_addr  <= addr_sel_c;
            pend_wdata <= acc_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
